// File: rtl/rx_comma_align_gearbox_pkg.sv
// rtl/rx_comma_align_gearbox_pkg.sv - shared comma constants, FSM states and offset width helper
package rx_comma_align_gearbox_pkg;

    localparam logic [6:0] COMMA_P = 7'b1111100;
    localparam logic [6:0] COMMA_N = 7'b0000011;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } align_state_e;

    function automatic int offset_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/rx_comma_align_gearbox_locator.sv
// rtl/rx_comma_align_gearbox_locator.sv - priority comma finder, lowest bit position wins
module comma_locator
    import rx_comma_align_gearbox_pkg::*;
#(
    parameter int IN_W = 20
) (
    input  logic [2*IN_W-1:0]           window,
    output logic                        hit,
    output logic [offset_w(IN_W)-1:0]   p
);

    localparam int OW = offset_w(IN_W);

    // Scan downwards so the last assignment is the lowest matching position.
    always_comb begin
        hit = 1'b0;
        p   = '0;
        for (int i = IN_W - 1; i >= 0; i--) begin
            if (window[i +: 7] == COMMA_P || window[i +: 7] == COMMA_N) begin
                hit = 1'b1;
                p   = i[OW-1:0];
            end
        end
    end

endmodule

// File: rtl/rx_comma_align_gearbox.sv
// rtl/rx_comma_align_gearbox.sv - comma hunt/confirm/lock FSM and barrel-shift word aligner
module rx_comma_align_gearbox
    import rx_comma_align_gearbox_pkg::*;
#(
    parameter int IN_W      = 20,
    parameter int LOCK_CNT  = 3,
    parameter int LOSS_CNT  = 4,
    parameter int EVEN_ONLY = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [IN_W-1:0]             rx_data,
    input  logic                        rx_valid,
    input  logic                        realign,
    output logic [IN_W-1:0]             out_data,
    output logic                        out_valid,
    output logic                        aligned,
    output logic [offset_w(IN_W)-1:0]   align_offset,
    output logic                        comma_seen
);

    localparam int         OW     = offset_w(IN_W);
    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

    align_state_e        state;
    logic [OW-1:0]       cand;
    logic [3:0]          cnt;
    logic [3:0]          miss;
    logic [IN_W-1:0]     prev_word;
    logic [2*IN_W-1:0]   window;
    logic                hit;
    logic [OW-1:0]       p;
    logic [3:0]          cnt_inc;
    logic [3:0]          miss_inc;
    logic                slot_ok;

    assign window       = {rx_data, prev_word};
    assign cnt_inc      = (cnt == 4'hF) ? cnt : cnt + 4'd1;
    assign miss_inc     = (miss == 4'hF) ? miss : miss + 4'd1;
    assign slot_ok      = (EVEN_ONLY == 0) || (((int'(cand) / 10) % 2) == 0);
    assign align_offset = cand;

    comma_locator #(.IN_W(IN_W)) u_locator (
        .window (window),
        .hit    (hit),
        .p      (p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            cand       <= '0;
            cnt        <= '0;
            miss       <= '0;
            prev_word  <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            aligned    <= 1'b0;
            comma_seen <= 1'b0;
        end else begin
            if (rx_valid) begin
                out_data   <= window[cand +: IN_W];
                out_valid  <= 1'b1;
                comma_seen <= hit && (p == cand);
                prev_word  <= rx_data;
            end else begin
                out_valid  <= 1'b0;
                comma_seen <= 1'b0;
            end

            if (realign) begin
                state   <= HUNT;
                cnt     <= '0;
                miss    <= '0;
                aligned <= 1'b0;
            end else if (rx_valid && hit) begin
                case (state)
                    HUNT: begin
                        cand <= p;
                        cnt  <= 4'd1;
                        miss <= '0;
                        if (LOCK_C == 4'd1) begin
                            state   <= LOCKED;
                            aligned <= 1'b1;
                        end else begin
                            state <= CONFIRM;
                        end
                    end
                    CONFIRM: begin
                        if (p == cand) begin
                            cnt <= cnt_inc;
                            if (cnt_inc >= LOCK_C) begin
                                state   <= LOCKED;
                                aligned <= 1'b1;
                                miss    <= '0;
                            end
                        end else begin
                            cand <= p;
                            cnt  <= 4'd1;
                        end
                    end
                    LOCKED: begin
                        // Offset stays frozen; only off-offset commas erode lock.
                        if (p == cand) begin
                            if (slot_ok) miss <= '0;
                        end else if (miss_inc >= LOSS_C) begin
                            state   <= HUNT;
                            cnt     <= '0;
                            miss    <= '0;
                            aligned <= 1'b0;
                        end else begin
                            miss <= miss_inc;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule
